// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Brief    : Shared defaults and FSM state encoding for the matmul sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int DEFAULT_N  = 4;
    localparam int DEFAULT_IW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/idx_counter.sv
`default_nettype none
// ============================================================================
// Module   : idx_counter
// Brief    : Modulo-N index counter with count enable and wrap flag, so
//            several instances can be chained through o_wrap -> i_ce.
// Revision : 1.0 - initial release
// ============================================================================
module idx_counter #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          mr,
    input  logic          i_ce,
    output logic [IW-1:0] o_count,
    output logic          o_wrap
);

    localparam logic [IW-1:0] c_MAX = IW'(N - 1);

    logic [IW-1:0] r_count;
    logic          w_at_max;

    assign w_at_max = (r_count == c_MAX);
    assign o_wrap   = i_ce & w_at_max;
    assign o_count  = r_count;

    // Advance on enable, returning to zero after the last index.
    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            r_count <= '0;
        end else if (i_ce) begin
            r_count <= w_at_max ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matmul_sequencer
// Brief    : Sequences the N^3 operand reads of an NxN matrix multiply,
//            generates MAC strobes one cycle later and result writes one
//            cycle after the last product of each output element.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int IW = DEFAULT_IW
) (
    input  logic          clk,
    input  logic          mr,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic [IW-1:0] k,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last,
    output logic          wr_en,
    output logic [IW-1:0] wr_row,
    output logic [IW-1:0] wr_col
);

    localparam logic [IW-1:0] c_LAST = IW'(N - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_drain_cnt;
    logic          w_rd_en;
    logic          w_k_wrap;
    logic          w_col_wrap;
    logic          w_row_wrap;
    logic [IW-1:0] w_row;
    logic [IW-1:0] w_col;
    logic [IW-1:0] w_k;

    logic          r_mac_en;
    logic          r_mac_clr;
    logic          r_mac_last;
    logic [IW-1:0] r_mac_row;
    logic [IW-1:0] r_mac_col;
    logic          r_wr_en;
    logic [IW-1:0] r_wr_row;
    logic [IW-1:0] r_wr_col;

    // A read is issued every RUN cycle the operand source is ready.
    assign w_rd_en = (r_state == ST_RUN) & ~stall;

    // k advances fastest; col and row step only when the inner index wraps.
    idx_counter #(.N(N), .IW(IW)) u_k_cnt (
        .clk    (clk),
        .mr     (mr),
        .i_ce   (w_rd_en),
        .o_count(w_k),
        .o_wrap (w_k_wrap)
    );

    idx_counter #(.N(N), .IW(IW)) u_col_cnt (
        .clk    (clk),
        .mr     (mr),
        .i_ce   (w_k_wrap),
        .o_count(w_col),
        .o_wrap (w_col_wrap)
    );

    idx_counter #(.N(N), .IW(IW)) u_row_cnt (
        .clk    (clk),
        .mr     (mr),
        .i_ce   (w_col_wrap),
        .o_count(w_row),
        .o_wrap (w_row_wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the row wrap marks the read at (N-1,N-1,N-1).
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)       w_next = ST_RUN;
            ST_RUN:   if (w_row_wrap)  w_next = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt) w_next = ST_DONE;
            ST_DONE:                   w_next = ST_IDLE;
            default:                   w_next = ST_IDLE;
        endcase
    end

    // Two-cycle DRAIN timer, lets the last product reach the write stage.
    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            r_drain_cnt <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // MAC stage: read strobe and its k-position flags delayed one cycle.
    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            r_mac_en   <= 1'b0;
            r_mac_clr  <= 1'b0;
            r_mac_last <= 1'b0;
            r_mac_row  <= '0;
            r_mac_col  <= '0;
        end else begin
            r_mac_en   <= w_rd_en;
            r_mac_clr  <= w_rd_en & (w_k == '0);
            r_mac_last <= w_rd_en & (w_k == c_LAST);
            r_mac_row  <= w_row;
            r_mac_col  <= w_col;
        end
    end

    // Write stage: the final product of an element triggers its write.
    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            r_wr_en  <= 1'b0;
            r_wr_row <= '0;
            r_wr_col <= '0;
        end else begin
            r_wr_en <= r_mac_last;
            if (r_mac_last) begin
                r_wr_row <= r_mac_row;
                r_wr_col <= r_mac_col;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign rd_en    = w_rd_en;
    assign row      = w_row;
    assign col      = w_col;
    assign k        = w_k;
    assign mac_en   = r_mac_en;
    assign mac_clr  = r_mac_clr;
    assign mac_last = r_mac_last;
    assign wr_en    = r_wr_en;
    assign wr_row   = r_wr_row;
    assign wr_col   = r_wr_col;

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_sequencer
// Brief    : Self-checking bench for matmul_sequencer (N=4 and N=2 instances)
//            against a product-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;

    localparam int N    = 4;
    localparam int N3   = N * N * N;
    localparam int MAXC = 200;

    logic       clk = 1'b0;
    logic       mr, start, stall, start2, stall2;
    logic       busy, done, rd_en, mac_en, mac_clr, mac_last, wr_en;
    logic [2:0] row, col, k, wr_row, wr_col;
    logic       busy2, done2, rd2, men2, clr2, last2, wr2;
    logic [0:0] row2, col2, k2, wrr2, wrc2;

    int n_cmp = 0;
    int n_bad = 0;

    // Stall pattern, observed and expected per-cycle traces of the N=4 DUT.
    bit         st [MAXC];
    logic [6:0] obs_ctl [MAXC];
    logic [8:0] obs_idx [MAXC];
    logic [5:0] obs_wix [MAXC];
    logic [6:0] exp_ctl [MAXC];
    logic [8:0] exp_idx [MAXC];
    logic [5:0] exp_wix [MAXC];
    int         exp_done_t;
    logic       ab_any;
    logic [14:0] ab_idx;

    always #5 clk = ~clk;

    matmul_sequencer #(.N(4), .IW(3)) dut (
        .clk(clk), .mr(mr), .start(start), .stall(stall),
        .busy(busy), .done(done), .rd_en(rd_en),
        .row(row), .col(col), .k(k),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col)
    );

    matmul_sequencer #(.N(2), .IW(1)) dut2 (
        .clk(clk), .mr(mr), .start(start2), .stall(stall2),
        .busy(busy2), .done(done2), .rd_en(rd2),
        .row(row2), .col(col2), .k(k2),
        .mac_en(men2), .mac_clr(clr2), .mac_last(last2),
        .wr_en(wr2), .wr_row(wrr2), .wr_col(wrc2)
    );

    // ctl vector order: busy, done, rd_en, mac_en, mac_clr, mac_last, wr_en
    task automatic drive_job(input int ncyc, input bit hold, input int abort_t);
        @(posedge clk);
        #1 start = 1'b1;
        stall = st[0];
        @(posedge clk);
        for (int t = 1; t < ncyc; t++) begin
            #1;
            if (!hold) start = 1'b0;
            stall = st[t];
            #1;
            obs_ctl[t] = {busy, done, rd_en, mac_en, mac_clr, mac_last, wr_en};
            obs_idx[t] = {row, col, k};
            obs_wix[t] = {wr_row, wr_col};
            if (t == abort_t) begin
                #1 mr = 1'b1;
                #1;
                ab_any = busy | done | rd_en | mac_en | mac_clr | mac_last | wr_en;
                ab_idx = {row, col, k, wr_row, wr_col};
                #2 mr = 1'b0;
            end
            @(posedge clk);
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    // Reference: products are issued in row-major (row, col, k) order, one per
    // non-stalled RUN cycle; MAC one cycle later, write one cycle after that.
    task automatic build_model();
        int issued, last_rd, p;
        issued  = 0;
        last_rd = -1;
        for (int t = 0; t < MAXC; t++) begin
            exp_ctl[t] = '0;
            exp_idx[t] = '0;
            exp_wix[t] = '0;
        end
        for (int t = 1; t < MAXC; t++) begin
            if (issued < N3) begin
                p = issued;
                exp_ctl[t][6] = 1'b1;
                exp_idx[t] = {3'(p / (N * N)), 3'((p / N) % N), 3'(p % N)};
                if (!st[t]) begin
                    exp_ctl[t][4] = 1'b1;
                    if (t + 1 < MAXC) begin
                        exp_ctl[t+1][3] = 1'b1;
                        exp_ctl[t+1][2] = (p % N == 0);
                        exp_ctl[t+1][1] = (p % N == N - 1);
                    end
                    if ((p % N == N - 1) && (t + 2 < MAXC)) begin
                        exp_ctl[t+2][0] = 1'b1;
                        exp_wix[t+2] = {3'(p / (N * N)), 3'((p / N) % N)};
                    end
                    issued++;
                    if (issued == N3) last_rd = t;
                end
            end
        end
        exp_done_t = (last_rd < 0) ? -1 : last_rd + 3;
        if (last_rd >= 0) begin
            for (int t = last_rd + 1; t <= exp_done_t && t < MAXC; t++) exp_ctl[t][6] = 1'b1;
            if (exp_done_t < MAXC) exp_ctl[exp_done_t][5] = 1'b1;
        end
    endtask

    task automatic test_reset();
        start = 1'b0; stall = 1'b0; start2 = 1'b0; stall2 = 1'b0; mr = 1'b0;
        #2 mr = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, rd_en, mac_en, mac_clr, mac_last, wr_en, row, col, k, wr_row, wr_col} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_async: got %b want all zero",
                     {busy, done, rd_en, mac_en, mac_clr, mac_last, wr_en, row, col, k, wr_row, wr_col});
        end
        n_cmp++;
        if ({busy2, done2, rd2, men2, clr2, last2, wr2, row2, col2, k2, wrr2, wrc2} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_async_n2: got %b want all zero",
                     {busy2, done2, rd2, men2, clr2, last2, wr2, row2, col2, k2, wrr2, wrc2});
        end
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: busy got %b want 0 while mr high", busy);
        end
        start = 1'b0;
        #3 mr = 1'b0;
    endtask

    task automatic test_job(input string name, input int mode);
        int nst, ncyc;
        nst = 0;
        for (int t = 0; t < MAXC; t++) st[t] = 1'b0;
        if (mode == 1) for (int t = 20; t < 25; t++) st[t] = 1'b1;
        if (mode == 2) begin
            for (int t = 0; t < MAXC; t++) begin
                if (nst < 40 && $urandom_range(0, 3) == 0) begin
                    st[t] = 1'b1;
                    nst++;
                end
            end
        end
        build_model();
        if (exp_done_t < 0 || exp_done_t + 3 > MAXC) begin
            n_cmp++; n_bad++;
            $display("FAIL %s window: done cycle %0d want within %0d", name, exp_done_t, MAXC - 3);
            return;
        end
        ncyc = exp_done_t + 3;
        drive_job(ncyc, 1'b0, 0);
        for (int t = 1; t < ncyc; t++) begin
            n_cmp++;
            if (obs_ctl[t] !== exp_ctl[t]) begin
                n_bad++;
                $display("FAIL %s ctl t=%0d: got %b want %b", name, t, obs_ctl[t], exp_ctl[t]);
            end
            n_cmp++;
            if (obs_idx[t] !== exp_idx[t]) begin
                n_bad++;
                $display("FAIL %s idx t=%0d: got %h want %h", name, t, obs_idx[t], exp_idx[t]);
            end
            if (exp_ctl[t][0]) begin
                n_cmp++;
                if (obs_wix[t] !== exp_wix[t]) begin
                    n_bad++;
                    $display("FAIL %s wr_idx t=%0d: got %h want %h", name, t, obs_wix[t], exp_wix[t]);
                end
            end
        end
        if (mode == 0 || mode == 1) begin
            n_cmp++;
            if (obs_ctl[(mode == 0) ? 67 : 72][5] !== 1'b1) begin
                n_bad++;
                $display("FAIL %s done_cycle: got 0 want 1 at cycle %0d", name, (mode == 0) ? 67 : 72);
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 mr = 1'b1;
        #4 mr = 1'b0;
    endtask

    task automatic test_start_held();
        int ndone;
        for (int t = 0; t < MAXC; t++) st[t] = 1'b0;
        drive_job(72, 1'b1, 0);
        ndone = 0;
        for (int t = 1; t <= 68; t++) if (obs_ctl[t][5] === 1'b1) ndone++;
        n_cmp++;
        if (ndone != 1 || obs_ctl[67][5] !== 1'b1) begin
            n_bad++;
            $display("FAIL held_done: got %0d pulses (cycle67=%b) want 1 at cycle 67", ndone, obs_ctl[67][5]);
        end
        n_cmp++;
        if (obs_ctl[68][6] !== 1'b0) begin
            n_bad++;
            $display("FAIL held_idle: busy at cycle 68 got %b want 0", obs_ctl[68][6]);
        end
        n_cmp++;
        if ({obs_ctl[65][4], obs_ctl[66][4], obs_ctl[67][4], obs_ctl[68][4], obs_ctl[69][4]} !== 5'b00001) begin
            n_bad++;
            $display("FAIL held_restart: rd_en cycles 65..69 got %b want 00001",
                     {obs_ctl[65][4], obs_ctl[66][4], obs_ctl[67][4], obs_ctl[68][4], obs_ctl[69][4]});
        end
        apply_reset();
    endtask

    task automatic test_mr_abort();
        for (int t = 0; t < MAXC; t++) st[t] = 1'b0;
        drive_job(40, 1'b0, 30);
        n_cmp++;
        if (obs_ctl[30][4] !== 1'b1 || obs_idx[30] !== {3'd1, 3'd3, 3'd1}) begin
            n_bad++;
            $display("FAIL abort_pre: rd_en/idx at 30 got %b/%h want 1/%h", obs_ctl[30][4], obs_idx[30], {3'd1, 3'd3, 3'd1});
        end
        n_cmp++;
        if (ab_any !== 1'b0 || ab_idx !== 15'd0) begin
            n_bad++;
            $display("FAIL abort_now: strobes got %b idx got %h want 0/0", ab_any, ab_idx);
        end
        for (int t = 31; t < 40; t++) begin
            n_cmp++;
            if (obs_ctl[t] !== 7'd0) begin
                n_bad++;
                $display("FAIL abort_after t=%0d: ctl got %b want 0000000", t, obs_ctl[t]);
            end
        end
    endtask

    task automatic test_n2();
        logic [6:0] ectl;
        logic [2:0] eidx;
        logic [1:0] ewix;
        int p;
        @(posedge clk);
        #1 start2 = 1'b1;
        stall2 = 1'b0;
        @(posedge clk);
        for (int t = 1; t < 15; t++) begin
            #1 start2 = 1'b0;
            #1;
            ectl = '0;
            eidx = '0;
            ewix = '0;
            ectl[6] = (t <= 11);
            ectl[5] = (t == 11);
            if (t <= 8) begin
                p = t - 1;
                ectl[4] = 1'b1;
                eidx = {1'(p / 4), 1'((p / 2) % 2), 1'(p % 2)};
            end
            if (t >= 2 && t <= 9) begin
                p = t - 2;
                ectl[3] = 1'b1;
                ectl[2] = (p % 2 == 0);
                ectl[1] = (p % 2 == 1);
            end
            if (t >= 3 && t <= 10 && ((t - 3) % 2 == 1)) begin
                p = t - 3;
                ectl[0] = 1'b1;
                ewix = {1'(p / 4), 1'((p / 2) % 2)};
            end
            n_cmp++;
            if ({busy2, done2, rd2, men2, clr2, last2, wr2} !== ectl) begin
                n_bad++;
                $display("FAIL n2_ctl t=%0d: got %b want %b", t, {busy2, done2, rd2, men2, clr2, last2, wr2}, ectl);
            end
            n_cmp++;
            if ({row2, col2, k2} !== eidx) begin
                n_bad++;
                $display("FAIL n2_idx t=%0d: got %b want %b", t, {row2, col2, k2}, eidx);
            end
            if (ectl[0]) begin
                n_cmp++;
                if ({wrr2, wrc2} !== ewix) begin
                    n_bad++;
                    $display("FAIL n2_wr_idx t=%0d: got %b want %b", t, {wrr2, wrc2}, ewix);
                end
            end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_job("nostall", 0);
        test_job("stall5", 1);
        test_job("rand_a", 2);
        test_job("rand_b", 2);
        test_start_held();
        test_mr_abort();
        test_job("after_abort", 0);
        test_n2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter N, default 4, matrix dimension (square NxN x NxN); SHALL be 2..8.
REQ-002 Parameter IW, default 3, index width; SHALL satisfy 2^IW >= N.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 mr  input  1  master reset, asynchronous, active-high.
REQ-005 start  input  1  request one full matrix multiply; sampled only in IDLE.
REQ-006 stall  input  1  operand source not ready; freezes index advance.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 rd_en  output  1  operand read strobe for A[row][k] and B[k][col].
REQ-010 row, col, k  output  IW each  current operand indices.
REQ-011 mac_en  output  1  accumulate strobe, rd_en delayed one cycle.
REQ-012 mac_clr  output  1  accumulator load-not-add, valid with mac_en, marks k==0 product.
REQ-013 mac_last  output  1  valid with mac_en, marks k==N-1 product.
REQ-014 wr_en  output  1  result write strobe for C[wr_row][wr_col].
REQ-015 wr_row, wr_col  output  IW each  result indices, valid when wr_en=1.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 -> RUN, with row=col=k=0; start=0 -> stay IDLE.
REQ-018 RUN: rd_en = ~stall; when rd_en=1 the index triple SHALL advance k fastest, then col, then row, each modulo N.
REQ-019 RUN with stall=1: row/col/k SHALL hold, rd_en=0, and a bubble (mac_en=0) SHALL enter the pipeline.
REQ-020 RUN: rd_en=1 at (N-1,N-1,N-1) -> DRAIN and indices wrap to 0.
REQ-021 DRAIN SHALL last exactly 2 cycles, then DONE; DONE SHALL last 1 cycle with done=1, then IDLE.
REQ-022 mac_en/mac_clr/mac_last SHALL equal rd_en, (k==0)&rd_en, (k==N-1)&rd_en registered one cycle.
REQ-023 wr_en SHALL be mac_last registered one cycle; wr_row/wr_col SHALL be the row/col of that product.
REQ-024 Without stall, rd_en SHALL be high exactly N^3 consecutive cycles, wr_en exactly N^2 times, done in cycle N^3+3 after the start-accepting edge.
REQ-025 Each stall cycle SHALL delay done by exactly one cycle; stall outside RUN SHALL be ignored.
REQ-026 start while busy=1 (including the DONE cycle) SHALL be ignored and not queued.
REQ-027 Only one of rd_en-driven index advance per cycle; no index SHALL exceed N-1.

Reset
REQ-028 mr=1 SHALL immediately force IDLE, row=col=k=0, wr_row=wr_col=0, and busy, done, rd_en, mac_en, mac_clr, mac_last, wr_en all 0.
REQ-029 mr asserted mid-RUN or mid-DRAIN SHALL abort the job; no wr_en or done SHALL follow after release.
REQ-030 After mr deasserts, the first start SHALL be honoured on the next rising edge.

Structure
REQ-031 State encoding, default N, and IW SHALL live in a shared package, matmul_pkg.
REQ-032 One sub-module, idx_counter (modulo-N counter with ce, wrap output, async active-high mr), SHALL be instantiated three times, chained k->col->row via wrap.
REQ-033 Pipeline delay registers and FSM SHALL reside in matmul_sequencer.

Verification
REQ-034 N=4, start pulse, stall=0 -> rd_en 64 consecutive cycles, wr_en 16 pulses at (0,0)..(3,3) in row-major order, done in cycle 67.
REQ-035 N=4, stall=1 for 5 cycles mid-RUN -> indices frozen during stall, mac_en bubbles, done in cycle 72.
REQ-036 start held high through whole job -> exactly one job, done once, new job starts only after returning to IDLE.
REQ-037 mr pulsed at rd_en cycle 30 -> all outputs 0 immediately, no wr_en/done afterward, next start runs full 64-cycle job.
REQ-038 N=2, IW=1 -> 8 rd_en, mac_clr at k=0 and mac_last at k=1 per output, 4 wr_en, done in cycle 11.
